// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
//
// Round-robin arbiter that shares one resource between four requesters.
// A grant is issued one cycle after a request is seen in IDLE. It is held until
// one of three things happens: the owner pulses done, the owner drops its
// request, or the hold timer expires. The arbiter then spends exactly one dead
// cycle in IDLE before it issues the next grant. The search for the next owner
// starts just after the last-served requester, so a requester that keeps
// requesting waits for at most three other grants.
//
// Handshake: req[i] is a level. The arbiter answers it with a registered
// one-hot gnt, the encoded gnt_id and a gnt_valid qualifier. The owner releases
// the resource either with a one-cycle done pulse or by lowering req[i]. The
// arbiter ignores done while no grant is active. It also ignores requests from
// non-owners while a grant is active.
//
// Parameters:
//   MAX_HOLD  maximum cycles a grant may stay active (0 = no timeout)
//   TIMER_W   width of the hold timer
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   req[3:0]     request lines
//   done         release pulse from the current owner
//   gnt[3:0]     one-hot grant, all zero when no grant is active
//   gnt_id[1:0]  encoded index of the owner; qualify it with gnt_valid
//   gnt_valid    high while a grant is active
//   timeout      one-cycle pulse when the hold timer revoked the grant
//   dbg_state_o  current FSM state (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15,
  parameter int TIMER_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [0:0] dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // With MAX_HOLD = 0 the compare value is unused. Clamp it so the
  // subtraction cannot go negative.
  localparam int                 HOLD_LAST_I = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [TIMER_W-1:0] HOLD_LAST   = HOLD_LAST_I[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
  localparam logic               HOLD_EN     = (MAX_HOLD != 0);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  logic [0:0]         state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               timeout_q, timeout_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         last_q, last_d;

  // ---------------------------------------------------------------------------
  // Rotating priority search: try last+1, last+2, last+3, then last itself.
  // ---------------------------------------------------------------------------
  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = last_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Release conditions while BUSY
  // ---------------------------------------------------------------------------
  logic rel_done;
  logic rel_drop;
  logic rel_time;
  logic release_now;

  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[gnt_id_q];
    rel_time    = HOLD_EN && (timer_q == HOLD_LAST);
    release_now = (state_q == ST_BUSY) && (rel_done || rel_drop || rel_time);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    timer_d     = timer_q;
    last_d      = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d       = 4'b0001 << pick_idx;
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (release_now) begin
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          last_d      = gnt_id_q;
          timer_d     = '0;
          state_d     = ST_IDLE;
          // A timer expiry that coincides with a normal release is reported
          // as a normal release.
          timeout_d   = rel_time && !rel_done && !rel_drop;
        end else if (timer_q != TIMER_MAX) begin
          // Saturate so the timer cannot wrap when the timeout is disabled.
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 4'b0000;
        gnt_valid_d = 1'b0;
        timer_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
      last_q      <= 2'd3;   // requester 0 gets first priority after reset
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign gnt_valid   = gnt_valid_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule
